// File: rtl/calc1_port_driver.sv
// Request-side sequencer for one calc1 requester port: buffers whole operations,
// serialises them as cmd/op1 then 0/op2, and returns the single-cycle response.
module calc1_port_driver #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [0:3]  in_cmd,
  input  logic [0:31] in_op1,
  input  logic [0:31] in_op2,
  output logic [0:3]  req_cmd_out,
  output logic [0:31] req_data_out,
  input  logic [0:1]  out_resp,
  input  logic [0:31] out_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [0:3]  res_cmd,
  output logic [0:1]  res_resp,
  output logic [0:31] res_data,
  output logic        busy,
  output logic        stray_resp,
  output logic [0:7]  timeout_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {IDLE, SEND_OP1, SEND_OP2, WAIT_RESP, HOLD} state_e;
  state_e state_q, state_d;

  logic [0:3]  fifo_cmd [DEPTH];
  logic [0:31] fifo_op1 [DEPTH];
  logic [0:31] fifo_op2 [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic        empty, full, push, pop;

  logic [0:3]    cur_cmd_q, cur_cmd_d;
  logic [0:31]   cur_op1_q, cur_op1_d, cur_op2_q, cur_op2_d;
  logic [0:3]    req_cmd_q, req_cmd_d;
  logic [0:31]   req_data_q, req_data_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [0:3]    res_cmd_q, res_cmd_d;
  logic [0:1]    res_resp_q, res_resp_d;
  logic [0:31]   res_data_q, res_data_d;
  logic [0:7]    tocnt_q, tocnt_d;
  logic          stray_q, stray_d;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  // cmd 0 is a no-op: handshake completes but nothing is queued
  assign push  = in_valid && !full && (in_cmd != 4'd0);

  assign in_ready     = !full;
  assign busy         = (state_q != IDLE) || !empty;
  assign res_valid    = (state_q == HOLD);
  assign req_cmd_out  = req_cmd_q;
  assign req_data_out = req_data_q;
  assign res_cmd      = res_cmd_q;
  assign res_resp     = res_resp_q;
  assign res_data     = res_data_q;
  assign stray_resp   = stray_q;
  assign timeout_cnt  = tocnt_q;

  always_ff @(posedge c_clk) begin
    if (push) begin
      fifo_cmd[wr_q[AW-1:0]] <= in_cmd;
      fifo_op1[wr_q[AW-1:0]] <= in_op1;
      fifo_op2[wr_q[AW-1:0]] <= in_op2;
    end
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_q       <= '0;
      rd_q       <= '0;
      cur_cmd_q  <= '0;
      cur_op1_q  <= '0;
      cur_op2_q  <= '0;
      req_cmd_q  <= '0;
      req_data_q <= '0;
      wait_q     <= '0;
      res_cmd_q  <= '0;
      res_resp_q <= '0;
      res_data_q <= '0;
      tocnt_q    <= '0;
      stray_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cur_cmd_q  <= cur_cmd_d;
      cur_op1_q  <= cur_op1_d;
      cur_op2_q  <= cur_op2_d;
      req_cmd_q  <= req_cmd_d;
      req_data_q <= req_data_d;
      wait_q     <= wait_d;
      res_cmd_q  <= res_cmd_d;
      res_resp_q <= res_resp_d;
      res_data_q <= res_data_d;
      tocnt_q    <= tocnt_d;
      stray_q    <= stray_d;
    end
  end

  // Port registers follow the state one cycle late, so cmd/op1 reaches the
  // port the cycle after SEND_OP1 and 0/op2 the cycle after SEND_OP2.
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    cur_cmd_d  = cur_cmd_q;
    cur_op1_d  = cur_op1_q;
    cur_op2_d  = cur_op2_q;
    req_cmd_d  = '0;
    req_data_d = '0;
    wait_d     = wait_q;
    res_cmd_d  = res_cmd_q;
    res_resp_d = res_resp_q;
    res_data_d = res_data_q;
    tocnt_d    = tocnt_q;
    stray_d    = stray_q || ((state_q != WAIT_RESP) && (out_resp != 2'd0));
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          cur_cmd_d = fifo_cmd[rd_q[AW-1:0]];
          cur_op1_d = fifo_op1[rd_q[AW-1:0]];
          cur_op2_d = fifo_op2[rd_q[AW-1:0]];
          state_d   = SEND_OP1;
        end
      end
      SEND_OP1: begin
        req_cmd_d  = cur_cmd_q;
        req_data_d = cur_op1_q;
        state_d    = SEND_OP2;
      end
      SEND_OP2: begin
        req_data_d = cur_op2_q;
        wait_d     = '0;
        state_d    = WAIT_RESP;
      end
      WAIT_RESP: begin
        wait_d = wait_q + 1'b1;
        // a response on the expiry cycle takes priority over the timeout
        if (out_resp != 2'd0) begin
          res_cmd_d  = cur_cmd_q;
          res_resp_d = out_resp;
          res_data_d = out_data;
          state_d    = HOLD;
        end else if (wait_q == CW'(TIMEOUT - 1)) begin
          res_cmd_d  = cur_cmd_q;
          res_resp_d = 2'd3;
          res_data_d = '0;
          if (tocnt_q != 8'hFF) tocnt_d = tocnt_q + 8'd1;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    wr_d = push ? wr_q + 1'b1 : wr_q;
    rd_d = pop  ? rd_q + 1'b1 : rd_q;
  end
endmodule

// File: doc/calc1_port_driver.md
Name: calc1_port_driver

Overview:
- Request-side sequencer sitting directly upstream of one calc1 requester port (one instance per port, up to four).
- Accepts whole operations (cmd, operand1, operand2) over a valid/ready handshake and buffers them in a small FIFO.
- Serialises each operation onto the calc1 two-cycle cmd/data protocol, waits for the single-cycle response, and returns it over a result handshake.
- Enforces one outstanding command per port, with a timeout for responses that never arrive.

Parameters:
DEPTH, 4, request FIFO entries (power of two, >=2)
TIMEOUT, 64, WAIT_RESP cycles before a missing response is declared (>=4)

Ports:
c_clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high
in_valid  input  1  operation offered
in_ready  output  1  FIFO can accept (= !full)
in_cmd  input  4  calc1 command, passed through unmodified
in_op1  input  32  first operand
in_op2  input  32  second operand
req_cmd_out  output  4  to calc1 reqN_cmd_in
req_data_out  output  32  to calc1 reqN_data_in
out_resp  input  2  from calc1 out_respN
out_data  input  32  from calc1 out_dataN
res_valid  output  1  result available
res_ready  input  1  result consumed
res_cmd  output  4  command echoed for this result
res_resp  output  2  calc1 response code, or 3 on timeout
res_data  output  32  calc1 result data, or 0 on timeout
busy  output  1  state != IDLE or FIFO non-empty
stray_resp  output  1  sticky: nonzero out_resp seen outside WAIT_RESP
timeout_cnt  output  8  saturating count of timeouts

Behaviour:
- All vectors use [0:N-1] ordering.
- Reset, applied on any cycle including mid-operation:
  - state IDLE, FIFO emptied.
  - req_cmd_out=0, req_data_out=0.
  - res_valid=0, res_* = 0.
  - stray_resp=0, timeout_cnt=0, busy=0; in_ready=1 the cycle after.
  - The driver does not reset calc1.
- FIFO push:
  - Push when in_valid & in_ready.
  - An in_cmd=0 push is accepted and discarded (never queued, no port activity).
  - in_ready depends only on full; a pop in the same cycle does not free a slot for that cycle's push.
- IDLE: if the FIFO is non-empty, pop the head and go to SEND_OP1.
- SEND_OP1, one cycle: req_cmd_out=cmd, req_data_out=op1.
- SEND_OP2, one cycle: req_cmd_out=0, req_data_out=op2.
- WAIT_RESP:
  - req_cmd_out=0, req_data_out=0. Wait counter starts at 0 on entry and increments each cycle.
  - On out_resp != 0: capture res_cmd/out_resp/out_data and go to HOLD.
  - On counter reaching TIMEOUT-1 with out_resp=0: res_resp=3, res_data=0, timeout_cnt+1 (saturating at 255), go to HOLD.
  - If the response arrives on the same cycle as expiry, the response wins.
- HOLD:
  - res_valid=1 with res_* stable until res_valid & res_ready, then return to IDLE.
  - No new command is issued while HOLD is occupied.
- Port drive timing:
  - req_cmd_out/req_data_out are registered and are 0 in IDLE and HOLD.
  - With the FIFO empty and state IDLE, an op accepted at edge N drives cmd/op1 between edges N+2 and N+3, then 0/op2 between N+3 and N+4.
- Stray responses: nonzero out_resp in any state other than WAIT_RESP sets stray_resp until reset. Typical case: a late response after a timeout. The response is otherwise ignored.
- Response codes are not interpreted. Codes 1/2/3 from calc1 pass through verbatim; invalid commands such as 3 or 4 are forwarded as-is.

Test Plan:
- Add: push {1, 0x0000_0001, 0x01FF_FFFF}; bench model answers resp 1, data 0x0200_0000 three cycles after op2.
  - Port shows cmd 1/0x1, then cmd 0/0x01FF_FFFF.
  - res_valid with res_cmd 1, res_resp 1, res_data 0x0200_0000.
- Overflow pass-through: push {1, 0xFFFF_FFFF, 0x0000_0001}; model answers resp 2.
  - res_resp 2, res_data as driven by the model.
- Back-pressure: DEPTH=4, res_ready=0, push 6 ops back-to-back.
  - Op1 is issued and held in HOLD; ops 2-5 are buffered; in_ready=0 and op6 is stalled.
  - After asserting res_ready, ops 2-6 complete in order.
- Timeout: TIMEOUT=16, model silent.
  - res_resp 3, res_data 0 on the 16th WAIT_RESP cycle; timeout_cnt=1.
  - A model response 5 cycles later sets stray_resp=1 and produces no res_valid.
- Reset mid-operation: assert reset during WAIT_RESP with 2 ops queued.
  - Next cycle: req_cmd_out=0, res_valid=0, busy=0, in_ready=1.
  - The queued ops never appear on the port.
- cmd 0 / invalid: push {0, 5, 5} -> accepted, no port activity. Push {3, 1, 0}; model answers resp 2 -> res_cmd 3, res_resp 2.
